// File: rtl/minrv32_mem_responder.sv
// minrv32_mem_responder: valid/ready word RAM responder with byte strobes/masks, wait states and error flag.
// Optional read/write completion counters are enabled by defining MINRV32_MEM_RESP_STATS_EN.
module minrv32_mem_responder #(
    parameter int          DEPTH_LOG2  = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    input  logic [3:0]  mem_rmask,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        mem_err,
    output logic [31:0] stat_reads,
    output logic [31:0] stat_writes
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP, TURN} state_t;
    state_t state, next_state;
    logic [31:0] ram [2**DEPTH_LOG2];
    logic [31:0] addr_q, wdata_q, rdata_q, req_addr, req_off, rd_word;
    logic [3:0]  wstrb_q, rmask_q, req_wstrb, req_rmask, cnt;
    logic [DEPTH_LOG2-1:0] idx_q;
    logic err_q, req_err, accept, enter_resp, unused_instr;

    assign unused_instr = mem_instr;
    assign accept       = state == IDLE && mem_valid;
    // In IDLE the live inputs are used so a zero-wait request resolves on its accepting edge
    assign req_addr   = state == IDLE ? mem_addr  : addr_q;
    assign req_wstrb  = state == IDLE ? mem_wstrb : wstrb_q;
    assign req_rmask  = state == IDLE ? mem_rmask : rmask_q;
    assign req_off    = req_addr - BASE_ADDR;
    assign req_err    = |req_off[1:0] || |req_off[31:DEPTH_LOG2+2];
    assign rd_word    = ram[req_off[DEPTH_LOG2+1:2]];
    assign enter_resp = next_state == RESP;

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = mem_valid ? (WAIT_STATES > 0 ? WAIT : RESP) : IDLE;
            WAIT:    next_state = !mem_valid ? IDLE : (cnt == 4'd0 ? RESP : WAIT);
            RESP:    next_state = TURN;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else       state <= next_state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rmask_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            if (accept) begin
                addr_q  <= mem_addr;
                wdata_q <= mem_wdata;
                wstrb_q <= mem_wstrb;
                rmask_q <= mem_rmask;
                cnt     <= 4'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (enter_resp) begin
                err_q <= req_err;
                idx_q <= req_off[DEPTH_LOG2+1:2];
            end
            rdata_q <= enter_resp && !req_err && req_wstrb == 4'd0
                     ? rd_word & {{8{req_rmask[3]}}, {8{req_rmask[2]}}, {8{req_rmask[1]}}, {8{req_rmask[0]}}}
                     : '0;
        end
    end

    // Write commits on the edge that ends RESP; a reset before then drops it
    always_ff @(posedge clk)
        if (state == RESP && !err_q)
            for (int i = 0; i < 4; i++)
                if (wstrb_q[i]) ram[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];

    assign mem_ready = state == RESP;
    assign mem_err   = mem_ready && err_q;
    assign mem_rdata = rdata_q;

`ifdef MINRV32_MEM_RESP_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_reads  <= '0;
            stat_writes <= '0;
        end else if (mem_ready && !err_q) begin
            if (wstrb_q == 4'd0) stat_reads  <= stat_reads + 32'd1;
            else                 stat_writes <= stat_writes + 32'd1;
        end
    end
`else
    assign stat_reads  = '0;
    assign stat_writes = '0;
`endif
endmodule

// File: tb/tb_minrv32_mem_responder.sv
// tb_minrv32_mem_responder: scoreboard bench for two responders (0 and 3 wait states, different bases)
// checked against a word-array reference model.
module tb_minrv32_mem_responder;
    typedef struct {
        int          inst;
        logic        err;
        logic [31:0] rdata;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        valid [2];
    logic        instr [2];
    logic        ready [2];
    logic        err [2];
    logic [31:0] addr [2];
    logic [31:0] wdata [2];
    logic [31:0] rdata [2];
    logic [31:0] sr [2];
    logic [31:0] sw [2];
    logic [3:0]  wstrb [2];
    logic [3:0]  rmask [2];
    int          ws [2] = '{0, 3};
    logic [31:0] base [2] = '{32'h0000_0000, 32'h0000_2000};
    logic [31:0] mdl [2][1024];
    int          nrd [2];
    int          nwr [2];
    exp_t        q [$];
    exp_t        got;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    minrv32_mem_responder #(.DEPTH_LOG2(10), .BASE_ADDR(32'h0000_0000), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(reset), .mem_valid(valid[0]), .mem_instr(instr[0]), .mem_addr(addr[0]),
        .mem_wdata(wdata[0]), .mem_wstrb(wstrb[0]), .mem_rmask(rmask[0]), .mem_ready(ready[0]),
        .mem_rdata(rdata[0]), .mem_err(err[0]), .stat_reads(sr[0]), .stat_writes(sw[0]));

    minrv32_mem_responder #(.DEPTH_LOG2(10), .BASE_ADDR(32'h0000_2000), .WAIT_STATES(3)) dut3 (
        .clk(clk), .reset(reset), .mem_valid(valid[1]), .mem_instr(instr[1]), .mem_addr(addr[1]),
        .mem_wdata(wdata[1]), .mem_wstrb(wstrb[1]), .mem_rmask(rmask[1]), .mem_ready(ready[1]),
        .mem_rdata(rdata[1]), .mem_err(err[1]), .stat_reads(sr[1]), .stat_writes(sw[1]));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk)
        for (int k = 0; k < 2; k++)
            if (ready[k] === 1'b1) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_ready dut%0d at cycle %0d: got ready=1 expected none", k, cyc);
                end else begin
                    got = q.pop_front();
                    if (got.inst != k || got.err !== err[k] || got.rdata !== rdata[k] || got.due != cyc) begin
                        errors++;
                        $display("FAIL response dut%0d: got err=%0b rdata=%h cycle=%0d, expected dut%0d err=%0b rdata=%h cycle=%0d",
                                 k, err[k], rdata[k], cyc, got.inst, got.err, got.rdata, got.due);
                    end
                end
            end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model(input int k, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         input logic [3:0] m, output logic e, output logic [31:0] r);
        int idx;
        e = (a % 4 != 0) || (a < base[k]) || (a >= base[k] + 32'd4096);
        r = '0;
        if (!e) begin
            idx = int'((a - base[k]) / 4);
            if (s != 4'd0) begin
                for (int i = 0; i < 4; i++) if (s[i]) mdl[k][idx][8*i +: 8] = d[8*i +: 8];
                nwr[k]++;
            end else begin
                for (int i = 0; i < 4; i++) if (m[i]) r[8*i +: 8] = mdl[k][idx][8*i +: 8];
                nrd[k]++;
            end
        end
    endtask

    task automatic txn(input int k, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       input logic [3:0] m, input bit hold);
        exp_t e;
        int n;
        @(negedge clk);
        valid[k] = 1'b1;
        instr[k] = 1'($urandom_range(0, 1));
        addr[k]  = a;
        wdata[k] = d;
        wstrb[k] = s;
        rmask[k] = m;
        model(k, a, d, s, m, e.err, e.rdata);
        e.inst = k;
        e.due  = cyc + 1 + ws[k];
        q.push_back(e);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ready[k] !== 1'b1 && n < 30);
        if (ready[k] !== 1'b1) begin
            check("ready_timeout", 32'(ready[k]), 32'd1);
            q.delete();
        end
        if (!hold) valid[k] = 1'b0;
        @(negedge clk);
        valid[k] = 1'b0;
        addr[k]  = $urandom;
        wdata[k] = $urandom;
        wstrb[k] = 4'($urandom);
        rmask[k] = 4'($urandom);
    endtask

    task automatic check_stats;
        for (int k = 0; k < 2; k++) begin
`ifdef MINRV32_MEM_RESP_STATS_EN
            check("stat_reads", sr[k], 32'(nrd[k]));
            check("stat_writes", sw[k], 32'(nwr[k]));
`else
            check("stat_reads", sr[k], 32'd0);
            check("stat_writes", sw[k], 32'd0);
`endif
        end
    endtask

    function automatic logic [31:0] pick_addr(input int k);
        int r = $urandom_range(0, 9);
        int w = $urandom_range(0, 16);
        logic [31:0] wa = base[k] + 32'(4 * (w == 16 ? 1023 : w));
        if (r == 0) return wa + 32'($urandom_range(1, 3));
        if (r == 1) return $urandom_range(0, 1) ? base[k] + 32'd4096 + 32'(4 * $urandom_range(0, 255)) : base[k] - 32'd4;
        return wa;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            valid[k] = 1'b0; instr[k] = 1'b0; addr[k] = '0; wdata[k] = '0; wstrb[k] = '0; rmask[k] = '0;
            nrd[k] = 0; nwr[k] = 0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("reset_ready", 32'(ready[k]), 32'd0);
            check("reset_err", 32'(err[k]), 32'd0);
            check("reset_rdata", rdata[k], 32'd0);
        end
        check_stats();
        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            for (int w = 0; w < 16; w++) txn(k, base[k] + 32'(4 * w), $urandom, 4'hF, 4'h0, 1'($urandom_range(0, 1)));
            txn(k, base[k] + 32'hFFC, $urandom, 4'hF, 4'h0, 1'b0);
        end
        txn(0, 32'h10, 32'hDEADBEEF, 4'hF, 4'h0, 1'b0);
        txn(0, 32'h10, 32'h0, 4'h0, 4'hF, 1'b0);
        txn(0, 32'h10, 32'h0000_5500, 4'b0010, 4'h0, 1'b1);
        txn(0, 32'h10, 32'h0, 4'h0, 4'b0011, 1'b0);
        txn(0, 32'h12, 32'h0, 4'h0, 4'hF, 1'b0);
        txn(0, 32'h1000, 32'h1234_5678, 4'hF, 4'h0, 1'b0);
        txn(0, 32'h0, 32'h0, 4'h0, 4'hF, 1'b0);
        txn(0, 32'hFFC, 32'h0, 4'h0, 4'hF, 1'b0);
        txn(1, 32'h2010, 32'h0, 4'h0, 4'hF, 1'b1);
        txn(1, 32'h1FFC, 32'h0, 4'h0, 4'hF, 1'b0);
        txn(1, 32'h3000, 32'h0, 4'hF, 4'h0, 1'b0);
        // Drop mem_valid while waiting: the write must not land and no ready may follow
        @(negedge clk);
        valid[1] = 1'b1; addr[1] = 32'h2004; wdata[1] = 32'hA5A5_A5A5; wstrb[1] = 4'hF;
        @(negedge clk);
        valid[1] = 1'b0;
        repeat (8) @(negedge clk);
        txn(1, 32'h2004, 32'h0, 4'h0, 4'hF, 1'b0);
        // Reset in the middle of a waiting write
        @(negedge clk);
        valid[1] = 1'b1; addr[1] = 32'h2020; wdata[1] = 32'hCAFE_F00D; wstrb[1] = 4'hF;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("reset_mid_ready", 32'(ready[1]), 32'd0);
        valid[1] = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            nrd[k] = 0;
            nwr[k] = 0;
        end
        check_stats();
        for (int k = 0; k < 2; k++) begin
            txn(k, base[k] + 32'h20, 32'h0, 4'h0, 4'hF, 1'b0);
            txn(k, base[k] + 32'h4, 32'h0, 4'h0, 4'hF, 1'b0);
            txn(k, base[k] + 32'h8, 32'h1111_2222, 4'hF, 4'h0, 1'b0);
            txn(k, base[k] + 32'h3, 32'h0, 4'h0, 4'hF, 1'b0);
            txn(k, base[k] + 32'hC, 32'h3333_4444, 4'b1001, 4'h0, 1'b1);
            txn(k, base[k] + 32'h8, 32'h0, 4'h0, 4'hF, 1'b0);
        end
        check_stats();
        for (int n = 0; n < 300; n++) begin
            int k = n % 2;
            logic [3:0] s = $urandom_range(0, 1) ? 4'h0 : 4'($urandom);
            txn(k, pick_addr(k), $urandom, s, 4'($urandom), 1'($urandom_range(0, 1)));
        end
        repeat (4) @(negedge clk);
        check_stats();
        check("queue_empty", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/minrv32_mem_responder.md
Name: minrv32_mem_responder

Overview:
- Memory-side (responder) end of the minrv32 valid/ready memory interface: word-organised on-chip RAM answering mem_valid requests with mem_ready.
- Supports byte write strobes, byte read masks, a configurable wait-state count and error signalling for misaligned or out-of-range accesses.
- Sits between the core's data/instruction memory port and the testbench or SoC fabric.
- Also serves as the standard memory model for riscv-formal and directed core benches.

Parameters:
- DEPTH_LOG2, 10, log2 of RAM depth in 32-bit words (default 1024 words = 4 KiB).
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be aligned to 4*2^DEPTH_LOG2.
- WAIT_STATES, 0, extra cycles inserted before mem_ready (0..15).

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- mem_valid  input  1  request valid; initiator holds it until mem_ready.
- mem_instr  input  1  request is an instruction fetch (counted only, no functional effect).
- mem_addr  input  32  byte address.
- mem_wdata  input  32  write data.
- mem_wstrb  input  4  byte write enables; nonzero = write.
- mem_rmask  input  4  byte read mask; used when mem_wstrb == 0.
- mem_ready  output  1  one-cycle completion pulse.
- mem_rdata  output  32  read data, valid while mem_ready is high.
- mem_err  output  1  error flag, valid while mem_ready is high.
- stat_reads  output  32  completed read count (optional feature).
- stat_writes  output  32  completed write count (optional feature).

Behaviour:
- Reset values: state IDLE, mem_ready 0, mem_rdata 0, mem_err 0, wait counter 0, stat counters 0. RAM contents are not reset.
- FSM states and transitions:
  - IDLE: mem_valid sampled high → WAIT if WAIT_STATES > 0, else RESP. Request fields are latched on this edge.
  - WAIT: counter counts WAIT_STATES-1 down to 0, then → RESP.
  - RESP: mem_ready = 1 for exactly one cycle, then → TURN.
  - TURN: mem_ready = 0 for one cycle, then → IDLE. This prevents re-accepting the same held request.
- Latency: mem_valid sampled in IDLE at edge N; mem_ready is high during cycle N+1+WAIT_STATES.
- mem_valid drops in WAIT (protocol violation): abort to IDLE, no write, no ready.
- Error conditions (checked on latched fields):
  - addr[1:0] != 0, or
  - addr outside [BASE_ADDR, BASE_ADDR + 4*2^DEPTH_LOG2).
  - Response on error: mem_err = 1 with mem_ready, mem_rdata = 0, no RAM write.
- Word index = (addr - BASE_ADDR) >> 2, truncated to DEPTH_LOG2 bits.
- Write (wstrb != 0, no error):
  - Bytes with strobe set are written on the edge ending the RESP cycle.
  - mem_rdata = 0 during RESP.
- Read (wstrb == 0, no error):
  - mem_rdata byte i = RAM byte i if rmask[i], else 0.
  - Data is registered at the edge entering RESP.
  - rmask == 0 is legal: ready with rdata 0.
- Read-after-write to the same word: the new request is accepted only after TURN, so it always returns the updated data.
- Asynchronous reset mid-transaction: immediate IDLE and mem_ready low. A write not yet committed (before the RESP edge) is dropped.
- Inputs other than mem_valid are don't-care in IDLE when mem_valid is low.

Optional Feature:
MINRV32_MEM_RESP_STATS_EN
- Defined:
  - stat_reads increments on each non-error read completion.
  - stat_writes increments on each non-error write completion.
  - Both are 32-bit wrapping counters, cleared by reset.
  - Instruction fetches (mem_instr = 1) count as reads.
- Undefined: stat_reads and stat_writes are tied to 0 and no counter logic is generated.

Test Plan:
- WAIT_STATES=0: write addr 0x10, wdata 0xDEADBEEF, wstrb 4'hF; then read addr 0x10, rmask 4'hF → ready 1 cycle after each accept, rdata 0xDEADBEEF, err 0.
- Byte strobes: with word 0x10 = 0xDEADBEEF, write wstrb 4'b0010, wdata 0x0000_5500; read rmask 4'b0011 → rdata 0x0000_55EF.
- WAIT_STATES=3: read with mem_valid held → mem_ready high exactly in cycle N+4, single-cycle pulse, no second ready while valid is held through TURN.
- Errors: read addr 0x12 → err 1, rdata 0. Write addr BASE_ADDR+0x1000 (DEPTH_LOG2=10) → err 1, and a subsequent read of word 0 is unchanged.
- Assert reset during WAIT of a write to 0x20 (WAIT_STATES=2) → mem_ready stays 0, word 0x20 keeps its prior value, FSM is back in IDLE.
- With MINRV32_MEM_RESP_STATS_EN: 3 reads, 2 writes, 1 error → stat_reads 3, stat_writes 2. Without the macro both read 0.
